// File: rtl/audio_pkg.sv
// Shared constants and types for the audio output path.
package audio_pkg;

  localparam int unsigned SLOT_BITS     = 32;
  localparam int unsigned FRAME_BITS    = 64;
  localparam int unsigned DEF_DATA_BITS = 20;
  localparam int unsigned DEF_BCLK_DIV  = 16;
  localparam int unsigned DEF_MCLK_DIV  = 4;

  // Word-select meaning of lrck.
  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S clock generator: MCLK, BCLK and LRCK plus bit, slot and frame ticks.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV = DEF_BCLK_DIV,
  parameter int unsigned MCLK_DIV = DEF_MCLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic bclk,
  output logic lrck,
  output logic mclk,
  output logic bit_tick,
  output logic slot_tick,
  output logic frame_tick
);

  localparam int unsigned DW = $clog2(BCLK_DIV);
  localparam int unsigned MW = $clog2(MCLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(BCLK_DIV / 2);
  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_DIV - 1);
  localparam logic [MW-1:0] MCLK_HALF = MW'(MCLK_DIV / 2);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic [5:0]    bit_cnt;
  logic [MW-1:0] mclk_cnt;
  logic [MW-1:0] mclk_next;
  slot_e         slot;

  // Next counter values and the tick strobes decoded from the current counts.
  always_comb begin
    bit_tick   = (div_cnt == DIV_LAST);
    slot_tick  = bit_tick && (bit_cnt[4:0] == 5'd31);
    frame_tick = bit_tick && (bit_cnt == 6'd63);
    div_next   = bit_tick ? '0 : div_cnt + DW'(1);
    mclk_next  = (mclk_cnt == MCLK_LAST) ? '0 : mclk_cnt + MW'(1);
  end

  // Counters and registered clock outputs; clocks are decoded from the next
  // count so each clock level lines up with the count it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      mclk_cnt <= '0;
      bclk     <= 1'b0;
      mclk     <= 1'b0;
    end else begin
      div_cnt  <= div_next;
      bclk     <= (div_next >= DIV_HALF);
      mclk_cnt <= mclk_next;
      mclk     <= (mclk_next >= MCLK_HALF);
      if (bit_tick) begin
        bit_cnt <= bit_cnt + 6'd1;
      end
    end
  end

  assign slot = slot_e'(bit_cnt[5]);
  assign lrck = (slot == SLOT_RIGHT);

endmodule

// File: rtl/i2s_dac_tx.sv
// Philips I2S transmitter: latches one mono sample per frame, converts it from
// offset binary to two's complement and sends it in both channel slots.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV  = DEF_BCLK_DIV,
  parameter int unsigned MCLK_DIV  = DEF_MCLK_DIV,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] sample_in,
  input  logic                 mute,
  output logic                 sample_strobe,
  output logic                 mclk,
  output logic                 bclk,
  output logic                 lrck,
  output logic                 sdata
);

  localparam int unsigned PAD = SLOT_BITS - DATA_BITS;

  logic                 bit_tick;
  logic                 slot_tick;
  logic                 frame_tick;
  logic [DATA_BITS-1:0] word;
  logic [DATA_BITS-1:0] word_next;
  logic [SLOT_BITS-1:0] shreg;

  i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV),
    .MCLK_DIV (MCLK_DIV)
  ) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .bclk       (bclk),
    .lrck       (lrck),
    .mclk       (mclk),
    .bit_tick   (bit_tick),
    .slot_tick  (slot_tick),
    .frame_tick (frame_tick)
  );

  // Held word, replaced only on the frame capture cycle (MSB flip = offset
  // binary to two's complement).
  always_comb begin
    word_next = word;
    if (frame_tick) begin
      word_next = mute ? '0 : {~sample_in[DATA_BITS-1], sample_in[DATA_BITS-2:0]};
    end
  end

  // Slot serialiser: at each slot start sdata carries the one-BCLK delay bit
  // (0) and the shifter is preloaded with the word, so the MSB follows next.
  always_ff @(posedge clk) begin
    if (reset) begin
      word  <= '0;
      shreg <= '0;
      sdata <= 1'b0;
    end else begin
      word <= word_next;
      if (bit_tick) begin
        if (slot_tick) begin
          sdata <= 1'b0;
          shreg <= {word_next, {PAD{1'b0}}};
        end else begin
          sdata <= shreg[SLOT_BITS-1];
          shreg <= {shreg[SLOT_BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign sample_strobe = frame_tick;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Scoreboard bench for i2s_dac_tx: a timing model predicts clocks and strobes
// per cycle and queues the expected word at every capture; a monitor decodes
// each 64-bit frame on bclk rising edges and compares it against the queue.
module tb_i2s_dac_tx;

  localparam int D  = 16;
  localparam int M  = 4;
  localparam int F  = 64 * D;
  localparam int D8 = 8;
  localparam int M8 = 2;
  localparam int F8 = 64 * D8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mute = 1'b0;
  logic [19:0] sample_in = '0;

  logic sample_strobe, mclk, bclk, lrck, sdata;
  logic sample_strobe8, mclk8, bclk8, lrck8, sdata8;

  int errors = 0;
  int checks = 0;
  int k = 0;
  bit valid = 1'b0;
  bit seen16 = 1'b0;
  bit seen8 = 1'b0;
  logic [19:0] exp_q[$];

  i2s_dac_tx dut (
    .clk           (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .mute          (mute),
    .sample_strobe (sample_strobe),
    .mclk          (mclk),
    .bclk          (bclk),
    .lrck          (lrck),
    .sdata         (sdata)
  );

  i2s_dac_tx #(
    .BCLK_DIV  (8),
    .MCLK_DIV  (2),
    .DATA_BITS (20)
  ) dut8 (
    .clk           (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .mute          (mute),
    .sample_strobe (sample_strobe8),
    .mclk          (mclk8),
    .bclk          (bclk8),
    .lrck          (lrck8),
    .sdata         (sdata8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, k);
    end
  endtask

  // Expected 64-bit frame, first transmitted bit in the MSB.
  function automatic logic [63:0] frame_of(input logic [19:0] w);
    logic [31:0] slot;
    slot = '0;
    for (int p = 1; p <= 20; p++) slot[31-p] = w[20-p];
    return {slot, slot};
  endfunction

  // Timing model: cycle k counts from the first clock after reset releases.
  always @(negedge clk) begin
    if (reset) begin
      valid = 1'b1;
      k = 0;
      seen16 = 1'b0;
      seen8 = 1'b0;
      exp_q.delete();
      exp_q.push_back('0);
    end else if (valid) begin
      if (k == 0) begin
        check("zero_after_reset", 64'({bclk, lrck, sdata, mclk, sample_strobe}), 64'(0));
        check("zero_after_reset8", 64'({bclk8, lrck8, sdata8, mclk8, sample_strobe8}), 64'(0));
      end
      check("bclk", 64'(bclk), 64'((k % D) >= D / 2));
      check("lrck", 64'(lrck), 64'(((k / D) % 64) >= 32));
      check("mclk", 64'(mclk), 64'((k % M) >= M / 2));
      check("strobe", 64'(sample_strobe), 64'((k % F) == F - 1));
      check("bclk8", 64'(bclk8), 64'((k % D8) >= D8 / 2));
      check("lrck8", 64'(lrck8), 64'(((k / D8) % 64) >= 32));
      check("mclk8", 64'(mclk8), 64'((k % M8) >= M8 / 2));
      check("strobe8", 64'(sample_strobe8), 64'((k % F8) == F8 - 1));
      if (sample_strobe && !seen16) begin
        seen16 = 1'b1;
        check("first_strobe", 64'(k), 64'(F - 1));
      end
      if (sample_strobe8 && !seen8) begin
        seen8 = 1'b1;
        check("first_strobe8", 64'(k), 64'(F8 - 1));
      end
      if ((k % F) == F - 1)
        exp_q.push_back(mute ? 20'h0 : (sample_in ^ 20'h80000));
      k++;
    end
  end

  logic [63:0] got_bits;
  logic [63:0] got_lr;
  int          nbits = 0;
  logic        prev_bclk = 1'b0;
  logic [19:0] exp_w;

  // Monitor: sample sdata/lrck at each bclk rise, compare every full frame.
  always @(negedge clk) begin
    if (reset) begin
      nbits = 0;
      prev_bclk = 1'b0;
    end else if (valid) begin
      if (bclk && !prev_bclk) begin
        got_bits[63-nbits] = sdata;
        got_lr[63-nbits] = lrck;
        nbits++;
        if (nbits == 64) begin
          check("lrck_frame", got_lr, {32'h0, 32'hFFFFFFFF});
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_queue: got frame %h expected none queued", got_bits);
          end else begin
            exp_w = exp_q.pop_front();
            check("frame", got_bits, frame_of(exp_w));
          end
          nbits = 0;
        end
      end
      prev_bclk = bclk;
    end
  end

  task automatic wait_mod(input int target);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (((k % F) != target) && (n < 5000));
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL wait_phase: got no cycle at %0d expected within 5000 clocks", target);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Free run with zero input (encodes as negative full scale).
    run(3000);

    // Boundary codes.
    sample_in = 20'hFFFFF;
    run(2 * F);
    sample_in = 20'h80000;
    run(2 * F);
    sample_in = 20'h00000;
    run(2 * F);

    // Mid-frame input change only takes effect after the next capture.
    wait_mod(100);
    sample_in = 20'h12345;
    wait_mod(0);
    wait_mod(500);
    sample_in = 20'hABCDE;
    wait_mod(0);
    run(2 * F);

    // Mute just before a capture, then just after one.
    sample_in = 20'hFFFFF;
    wait_mod(F - 2);
    mute = 1'b1;
    wait_mod(0);
    mute = 1'b0;
    wait_mod(0);
    mute = 1'b1;
    wait_mod(0);
    mute = 1'b0;
    run(2 * F);

    // Randomised inputs changing every cycle.
    repeat (4 * F) begin
      @(posedge clk);
      #1;
      sample_in = 20'($urandom);
      mute = ($urandom_range(0, 3) == 0);
    end
    mute = 1'b0;
    sample_in = 20'h7F00F;
    run(F);

    // One-clock reset at bit_cnt=40.
    wait_mod(40 * D);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    run(3 * F);

    if (!seen16 || !seen8) begin
      checks++;
      errors++;
      $display("FAIL strobe_seen: got %0d/%0d expected 1/1", seen16, seen8);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Output stage directly downstream of the ADSR envelope block.
- Takes the 20-bit enveloped voice sample and serialises it as a standard Philips I2S stream for the board audio DAC.
- Generates MCLK, BCLK and LRCK from the system clock and transmits the same mono sample in both channels.
- Latches one sample per frame and converts offset-binary to two's complement.

Parameters:
- BCLK_DIV, 16, system clocks per BCLK period; even, ≥4, multiple of 4 (50 MHz gives 3.125 MHz BCLK and 48.83 kHz fs).
- MCLK_DIV, 4, system clocks per MCLK period; even, ≥2. MCLK = 256·fs requires MCLK_DIV = BCLK_DIV/4.
- DATA_BITS, 20, input sample width; ≤ 31.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- sample_in  in  DATA_BITS  envelope output, unsigned offset binary.
- mute  in  1  when high, the next frame transmits zeros.
- sample_strobe  out  1  one-clk pulse on the cycle sample_in is latched.
- mclk  out  1  DAC master clock.
- bclk  out  1  bit clock.
- lrck  out  1  word select; 0 = left, 1 = right.
- sdata  out  1  serial data, MSB first.

Behaviour:
- Reset is synchronous, active-high; clock is clk.
- Reset values: div_cnt=0, bit_cnt=0, mclk_cnt=0, holding word=0, shift register=0. All outputs are 0.
- div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bclk is registered: 0 while div_cnt < BCLK_DIV/2, else 1.
  - A BCLK falling edge corresponds to div_cnt wrapping to 0.
- bit_cnt (6 bits) counts 0..63 and increments on each div_cnt wrap; 63 wraps to 0.
  - lrck = bit_cnt[5], so it changes on the BCLK falling edge.
  - bit_cnt 0..31 is the left slot; 32..63 is the right slot.
- mclk toggles every MCLK_DIV/2 clocks and is free-running. It is phase-aligned to div_cnt only at reset.
- Sample capture happens on the cycle where div_cnt=BCLK_DIV-1 and bit_cnt=63:
  - word = mute ? 0 : {~sample_in[DATA_BITS-1], sample_in[DATA_BITS-2:0]}.
  - sample_strobe is high for exactly that cycle.
  - sample_in and mute are ignored on all other cycles.
- Slot format (I2S, one-BCLK delay), with position p = bit_cnt mod 32:
  - p=0: sdata=0.
  - p=1..DATA_BITS: word[DATA_BITS-p].
  - p>DATA_BITS: 0.
- Left and right slots carry the identical word.
- sdata is registered and updates only at div_cnt wrap, i.e. the BCLK falling edge. It is stable across the BCLK rising edge.
- Latency: a sample captured at clk cycle T appears as the left MSB starting at T+1+BCLK_DIV.
- First capture after reset is at clk 64·BCLK_DIV-1 (1023 at default). The first frame after reset is all zeros.
- Reset mid-frame:
  - All counters and registers clear on the next edge.
  - bclk, lrck and sdata go to 0.
  - The held word is discarded and the framing restarts from bit_cnt=0. No partial-frame recovery.
- mute toggling mid-frame has no effect until the next capture; the frame in flight completes unmodified.
- Midscale input (1 << (DATA_BITS-1)) transmits as all-zero data.

Decomposition:
- Shared package audio_pkg holds:
  - SLOT_BITS=32, FRAME_BITS=64.
  - Default DATA_BITS=20 (matches the envelope output width).
  - Default BCLK_DIV=16 and MCLK_DIV=4.
- One natural sub-module, i2s_clkgen, owns div_cnt, bit_cnt and mclk_cnt. It outputs bclk, lrck, mclk, a bit_tick (div_cnt wrap) and a frame_tick (capture cycle).
- The top level holds the capture register, offset-binary conversion, mute, and the 32-bit slot shift register.

Test Plan:
- Reset, then 3000 clocks free-run with sample_in=0 → bclk period 16 clk at 50% duty; lrck period 1024 clk; mclk period 4 clk; first sample_strobe at cycle 1023, then every 1024.
- sample_in=20'hFFFFF held → each slot decodes (sampled on bclk rising edge) as 0, then 0,1×19, then 0×11; left equals right.
- sample_in=20'h80000 → all 64 bits zero; sample_in=20'h00000 → slot bits p1=1, p2..p20=0.
- Change sample_in only at non-capture cycles mid-frame, 20'h12345→20'hABCDE → the frame in flight keeps 20'h12345's word; 20'hABCDE appears only after the next strobe.
- mute=1 asserted one cycle before a strobe with sample_in=20'hFFFFF → that frame is all zeros; mute asserted one cycle after the strobe → the frame is unmuted and the following frame is zero.
- Assert reset for 1 clk at bit_cnt=40 → next cycle all outputs 0; the strobe recurs exactly 1023 clocks after reset deasserts; a rerun with BCLK_DIV=8, MCLK_DIV=2 gives lrck period 512 and the first strobe at 511.
